// File: rtl/smult_acc.sv
// Accumulates signed multiplier products into groups and emits a rounded,
// saturated N-bit fixed-point result through a valid/ready output register.
module smult_acc #(
    parameter int unsigned N     = 8,
    parameter int unsigned ACC_W = 2*N+4,
    parameter int unsigned FRAC  = N-1
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic           in_valid,
    input  logic [2*N-1:0] product,
    input  logic           clear,
    input  logic           last,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_data,
    output logic           out_sat,
    output logic [7:0]     out_count
);

    localparam int unsigned PW = 2*N;
    localparam int unsigned SW = ACC_W+1;
    localparam int unsigned HW = SW-N+1;

    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [N-1:0]     OUT_MAX  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]     OUT_MIN  = {1'b1, {(N-1){1'b0}}};
    localparam logic [SW-1:0]    RND_HALF = {{(SW-1){1'b0}}, 1'b1} << (FRAC-1);

    logic signed [ACC_W-1:0] acc;
    logic                    sat;
    logic [7:0]              cnt;

    logic                    accept;
    logic signed [SW-1:0]    sum_w;
    logic                    sum_ovf;
    logic signed [ACC_W-1:0] sum_cl;
    logic signed [SW-1:0]    rnd_w;
    logic signed [SW-1:0]    shf_w;
    logic [HW-1:0]           hi;
    logic                    res_clip;
    logic [N-1:0]            res;
    logic                    sat_nxt;
    logic [7:0]              cnt_base;
    logic [7:0]              cnt_nxt;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Accumulate one guard bit wide, then clamp back into the ACC_W range.
    always_comb begin
        sum_w    = '0;
        sum_ovf  = 1'b0;
        sum_cl   = '0;
        rnd_w    = '0;
        shf_w    = '0;
        hi       = '0;
        res_clip = 1'b0;
        res      = '0;
        sat_nxt  = 1'b0;
        cnt_base = '0;
        cnt_nxt  = '0;

        sum_w   = (clear ? {SW{1'b0}} : {acc[ACC_W-1], acc})
                + {{(SW-PW){product[PW-1]}}, product};
        sum_ovf = sum_w[SW-1] ^ sum_w[SW-2];
        if (!sum_ovf)
            sum_cl = sum_w[ACC_W-1:0];
        else
            sum_cl = sum_w[SW-1] ? ACC_MIN : ACC_MAX;
        sat_nxt = (!clear && sat) || sum_ovf;

        // Round half toward +inf, then drop the fractional bits.
        rnd_w    = {sum_cl[ACC_W-1], sum_cl} + RND_HALF;
        shf_w    = rnd_w >>> FRAC;
        hi       = shf_w[SW-1:N-1];
        res_clip = !((&hi) || !(|hi));
        if (res_clip)
            res = shf_w[SW-1] ? OUT_MIN : OUT_MAX;
        else
            res = shf_w[N-1:0];

        cnt_base = clear ? 8'd0 : cnt;
        cnt_nxt  = (cnt_base == 8'hFF) ? cnt_base : cnt_base + 8'd1;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc       <= '0;
            sat       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_count <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                if (last) begin
                    out_valid <= 1'b1;
                    out_data  <= res;
                    out_sat   <= sat_nxt || res_clip;
                    out_count <= cnt_nxt;
                    acc       <= '0;
                    sat       <= 1'b0;
                    cnt       <= '0;
                end else begin
                    acc       <= sum_cl;
                    sat       <= sat_nxt;
                    cnt       <= cnt_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_smult_acc.sv
// Bench for smult_acc: directed vector table, hand-written handshake/reset
// sequences and a randomized run against an arithmetic reference model.
module tb_smult_acc;

    localparam int N     = 8;
    localparam int ACC_W = 2*N+4;
    localparam int FRAC  = N-1;
    localparam longint AMAX = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (ACC_W-1));

    logic           clk;
    logic           n_reset;
    logic           in_valid;
    logic [2*N-1:0] product;
    logic           clear;
    logic           last;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_data;
    logic           out_sat;
    logic [7:0]     out_count;

    smult_acc #(.N(N), .ACC_W(ACC_W), .FRAC(FRAC)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_valid  (in_valid),
        .product   (product),
        .clear     (clear),
        .last      (last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    longint m_acc;
    bit     m_sat;
    int     m_cnt;
    bit     m_ov;
    int     m_od;
    bit     m_os;
    int     m_oc;

    typedef struct {
        bit iv;
        int prod;
        bit clr;
        bit lst;
        bit ordy;
        bit e_ov;
        int e_data;
        bit e_sat;
        int e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_sat = 0; m_cnt = 0;
        m_ov = 0; m_od = 0; m_os = 0; m_oc = 0;
    endtask

    function automatic int dut_data();
        logic signed [N-1:0] s;
        s = out_data;
        return int'(s);
    endfunction

    // Spec-level behaviour of one clock edge given the inputs.
    task automatic model_step(input bit iv, input int prod, input bit clr,
                              input bit lst, input bit ordy);
        bit     take;
        longint s;
        bit     st;
        int     c;
        longint r;
        take = iv && (!m_ov || ordy);
        if (m_ov && ordy) m_ov = 0;
        if (take) begin
            s  = (clr ? 64'sd0 : m_acc) + longint'(prod);
            st = clr ? 1'b0 : m_sat;
            if (s > AMAX) begin s = AMAX; st = 1; end
            if (s < AMIN) begin s = AMIN; st = 1; end
            c = (clr ? 0 : m_cnt) + 1;
            if (c > 255) c = 255;
            if (lst) begin
                r = (s + (64'sd1 <<< (FRAC-1))) >>> FRAC;
                if (r > 127)  begin r = 127;  st = 1; end
                if (r < -128) begin r = -128; st = 1; end
                m_ov = 1; m_od = int'(r); m_os = st; m_oc = c;
                m_acc = 0; m_sat = 0; m_cnt = 0;
            end else begin
                m_acc = s; m_sat = st; m_cnt = c;
            end
        end
    endtask

    // Apply one cycle of inputs, check in_ready, clock, check outputs vs model.
    task automatic cycle(input bit iv, input int prod, input bit clr,
                         input bit lst, input bit ordy, input string tag);
        in_valid  = iv;
        product   = (2*N)'(prod);
        clear     = clr;
        last      = lst;
        out_ready = ordy;
        #1;
        chk({tag, ".in_ready"}, longint'(in_ready), longint'(!m_ov || ordy));
        model_step(iv, prod, clr, lst, ordy);
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, longint'(out_valid), longint'(m_ov));
        chk({tag, ".out_data"},  longint'(dut_data()), longint'(m_od));
        chk({tag, ".out_sat"},   longint'(out_sat), longint'(m_os));
        chk({tag, ".out_count"}, longint'(out_count), longint'(m_oc));
    endtask

    task automatic add_vec(input bit iv, input int prod, input bit clr, input bit lst,
                           input bit ordy, input bit e_ov, input int e_data,
                           input bit e_sat, input int e_cnt);
        vec_t v;
        v.iv = iv; v.prod = prod; v.clr = clr; v.lst = lst; v.ordy = ordy;
        v.e_ov = e_ov; v.e_data = e_data; v.e_sat = e_sat; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    initial begin
        int p;
        int sel;

        n_reset = 1'b0; in_valid = 0; product = '0; clear = 0; last = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", longint'(out_valid), 0);
        chk("reset.out_data",  longint'(out_data), 0);
        chk("reset.out_count", longint'(out_count), 0);
        chk("reset.in_ready",  longint'(in_ready), 1);
        n_reset = 1'b1;

        // Directed vectors with hand-computed expectations.
        add_vec(1,   4096, 1, 1, 1,  1,   32, 0, 1);
        add_vec(1,     64, 1, 1, 1,  1,    1, 0, 1);
        add_vec(1,    -64, 1, 1, 1,  1,    0, 0, 1);
        add_vec(1,    -65, 1, 1, 1,  1,   -1, 0, 1);
        add_vec(1,  16384, 1, 0, 1,  0,   -1, 0, 1);
        add_vec(1,  16384, 0, 1, 1,  1,  127, 1, 2);
        add_vec(1, -16256, 1, 0, 1,  0,  127, 1, 2);
        add_vec(1, -16256, 0, 0, 1,  0,  127, 1, 2);
        add_vec(1, -16256, 0, 1, 1,  1, -128, 1, 3);
        add_vec(1,   4096, 1, 1, 1,  1,   32, 0, 1);
        add_vec(1,    128, 1, 1, 1,  1,    1, 0, 1);
        add_vec(0,      0, 0, 0, 1,  0,    1, 0, 1);
        foreach (vecs[i]) begin
            cycle(vecs[i].iv, vecs[i].prod, vecs[i].clr, vecs[i].lst, vecs[i].ordy,
                  $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_valid", i), longint'(out_valid), longint'(vecs[i].e_ov));
            chk($sformatf("vec%0d.tbl_data", i),  longint'(dut_data()), longint'(vecs[i].e_data));
            chk($sformatf("vec%0d.tbl_sat", i),   longint'(out_sat), longint'(vecs[i].e_sat));
            chk($sformatf("vec%0d.tbl_count", i), longint'(out_count), longint'(vecs[i].e_cnt));
        end

        // Back-pressure: result 32 held while a term is presented and refused.
        cycle(1, 4096, 1, 1, 1, "bp.load");
        chk("bp.load_data", longint'(dut_data()), 32);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 128, 1, 1, 0, "bp.stall");
            chk("bp.stall_ready", longint'(in_ready), 0);
            chk("bp.stall_valid", longint'(out_valid), 1);
            chk("bp.stall_data",  longint'(dut_data()), 32);
        end
        cycle(1, 128, 1, 1, 1, "bp.release");
        chk("bp.release_valid", longint'(out_valid), 1);
        chk("bp.release_data",  longint'(dut_data()), 1);
        cycle(0, 0, 0, 0, 1, "bp.drain");
        chk("bp.drain_valid", longint'(out_valid), 0);

        // Accumulator saturation: 17 terms of 32767 exceed the 20-bit range.
        cycle(1, 32767, 1, 0, 1, "accsat.first");
        for (int k = 0; k < 15; k++) cycle(1, 32767, 0, 0, 1, "accsat.mid");
        cycle(1, 32767, 0, 1, 1, "accsat.last");
        chk("accsat.data",  longint'(dut_data()), 127);
        chk("accsat.sat",   longint'(out_sat), 1);
        chk("accsat.count", longint'(out_count), 17);

        // Asynchronous reset in the middle of a group.
        cycle(1, 4096, 1, 1, 1, "rst.pre");
        cycle(1, 100, 1, 0, 1, "rst.t1");
        cycle(1, 200, 0, 0, 1, "rst.t2");
        #2;
        n_reset = 1'b0;
        #1;
        chk("rst.async_valid", longint'(out_valid), 0);
        chk("rst.async_data",  longint'(out_data), 0);
        chk("rst.async_count", longint'(out_count), 0);
        model_reset();
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        cycle(1, 4096, 0, 1, 1, "rst.after");
        chk("rst.after_data",  longint'(dut_data()), 32);
        chk("rst.after_count", longint'(out_count), 1);

        // Randomized run against the reference model.
        for (int k = 0; k < 3000; k++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0)
                p = int'($urandom_range(0, 65535)) - 32768;
            else if (sel == 1)
                p = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
            else
                p = int'($urandom_range(0, 1023)) - 512;
            cycle($urandom_range(0, 3) != 0, p,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smult_acc.md
Name: smult_acc

Overview:
- Downstream consumer of the registered signed multiplier in the picoMIPS datapath.
- Accepts the multiplier's 2N-bit signed product one cycle after operands are applied and accumulates a group of products (dot-product / affine-transform terms).
- At the end of a group, emits a rounded, saturated N-bit fixed-point result through a valid/ready output register.

Parameters:
- N, 8, operand width of the upstream multiplier; output width.
- ACC_W, 2*N+4, accumulator width in bits; must be ≥ 2*N.
- FRAC, N-1, fractional shift applied to the accumulator at output (Q1.(N-1) operands); must be ≥ 1.

Ports:
- clk, input, 1, rising-edge clock.
- n_reset, input, 1, asynchronous active-low reset.
- in_valid, input, 1, product is valid this cycle.
- product, input, 2*N, signed product from the multiplier.
- clear, input, 1, this term starts a new group; ignore the prior accumulator.
- last, input, 1, this term ends the group; produce an output.
- in_ready, output, 1, block can accept a term this cycle.
- out_valid, output, 1, out_data/out_sat/out_count are valid.
- out_ready, input, 1, consumer accepts the output this cycle.
- out_data, output, N, signed rounded, saturated result.
- out_sat, output, 1, saturation occurred anywhere in this group.
- out_count, output, 8, number of terms in the group; saturates at 255.

Behaviour:
- Reset: one clock; n_reset is asynchronous, active-low.
  - Asserting n_reset at any time clears acc, the sticky sat flag and the term counter.
  - It also forces out_valid=0, out_data=0, out_sat=0, out_count=0.
  - Any group in flight is discarded; no partial output is produced.
- Accept: a term is accepted on a rising edge where in_valid && in_ready. in_ready = !out_valid || out_ready (combinational).
- Accumulate on accept:
  - sum = (clear ? 0 : acc) + sign-extended product, computed at ACC_W+1 bits.
  - If sum exceeds the ACC_W signed range, clamp to the max/min value and set sticky sat.
  - clear also resets the sticky sat flag and the counter before this term is counted.
  - Counter increments by 1, saturating at 255.
- Output on accept with last=1:
  - rnd = sum_clamped + 2^(FRAC-1), then arithmetic shift right by FRAC (round half toward +inf).
  - Saturate to [-2^(N-1), 2^(N-1)-1]; any clamp here also sets out_sat.
  - out_data, out_sat and out_count load on the same edge; out_valid=1 the following cycle, so latency is 1 cycle from the accepting edge.
  - acc, sat and counter return to 0, so the next term starts a fresh group even without clear.
- clear and last together form a single-term group.
- Output hold: while out_valid && !out_ready, out_* stay stable and in_ready=0; no terms are accepted.
- Output release: on out_valid && out_ready, out_valid drops unless a new last term is accepted on the same edge, in which case the new result loads and out_valid stays 1.
- Non-last terms may be accepted while the output waits only if out_ready=1; they are never accepted while the output is stalled.
- in_valid=0: acc, counter and out_* are unchanged.
- A first term without clear after reset accumulates onto 0.

Test Plan:
- N=8. Single term 64*64: product=4096, clear=1, last=1, out_ready=1 → next cycle out_valid=1, out_data=32, out_sat=0, out_count=1.
- Rounding:
  - Single term product=64 → out_data=1.
  - Single term product=-64 → out_data=0.
  - Single term product=-65 → out_data=-1.
- Output saturation:
  - Two terms 16384, 16384 (clear on first, last on second) → out_data=127, out_sat=1, out_count=2.
  - Three terms of -16256 → out_data=-128, out_sat=1, out_count=3.
- Back-pressure:
  - Hold out_ready=0 after a result=32 → out_valid stays 1, data stable, in_ready=0, and a presented term is not accepted.
  - Raise out_ready → the held term is accepted next edge with no lost or duplicated output.
- Back-to-back groups: terms (4096,last), (128,clear,last) with out_ready=1 every cycle → outputs 32 then 1 on consecutive cycles, out_valid continuously high.
- Reset mid-operation: accept two non-last terms, pulse n_reset low mid-cycle → outputs are 0 immediately (asynchronous); a new single term 4096 with no clear then yields 32 and out_count=1.
